// File: rtl/data_mem_responder.sv
// Byte-addressed data memory answering CPU load/store requests with a fixed
// multi-cycle latency. Optional macro DMEM_POSTED_WRITE_EN gives 1-cycle stores.
module data_mem_responder #(
    parameter int DEPTH         = 256,
    parameter int ACCESS_CYCLES = 5
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] address,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       busywait
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [3:0]    counter;
    logic          op_write;
    logic [AW-1:0] addr_q;
    logic [7:0]    data_q;
    logic [7:0]    mem [DEPTH];

    // The request is stalled in the same cycle it appears; DONE forces one
    // low cycle so a request still held by the CPU is not taken twice.
    always_comb begin
        busywait = 1'b0;
        case (state)
            IDLE:    busywait = read | write;
            BUSY:    busywait = 1'b1;
            DONE:    busywait = 1'b0;
            default: busywait = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            counter  <= 4'd0;
            readdata <= 8'h00;
            op_write <= 1'b0;
            addr_q   <= '0;
            data_q   <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (read | write) begin
                        addr_q   <= address[AW-1:0];
                        data_q   <= writedata;
                        op_write <= write;
                        counter  <= 4'(ACCESS_CYCLES - 1);
`ifdef DMEM_POSTED_WRITE_EN
                        if (write) begin
                            mem[address[AW-1:0]] <= writedata;
                            state                <= DONE;
                        end else begin
                            state <= BUSY;
                        end
`else
                        state <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    if (counter != 4'd0) begin
                        counter <= counter - 4'd1;
                    end else begin
                        if (op_write) begin
                            mem[addr_q] <= data_q;
                        end else begin
                            readdata <= mem[addr_q];
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
